// File: rtl/qkv_frame_feeder.sv
// Frame feeder for binary_QKV: FILL buffers one frame, STREAM replays it once per pass,
// GAP idles between passes (and drains the read pipeline after the last), DONE pulses frame_done.
module qkv_frame_feeder #(
    parameter int DATA_W     = 16,
    parameter int FRAME_LEN  = 30,
    parameter int NUM_PASS   = 3,
    parameter int SEL_W      = 2,
    parameter int GAP_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_valid,
    output logic [SEL_W-1:0]  block_sel,
    output logic              frame_done,
    output logic              busy
);

    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    // Two extra counts let the last gap cover the two-stage read pipeline before DONE.
    localparam int GW = $clog2(GAP_CYCLES + 3);
    localparam logic [CW-1:0]    LAST_ADDR = CW'(FRAME_LEN - 1);
    localparam logic [SEL_W-1:0] LAST_PASS = SEL_W'(NUM_PASS - 1);

    typedef enum logic [1:0] {FILL, STREAM, GAP, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
    logic [SEL_W-1:0]  pass_q, pass_d;
    logic [GW-1:0]     gap_cnt_q, gap_cnt_d;

    logic [DATA_W-1:0] mem [FRAME_LEN];
    logic [DATA_W-1:0] ram_q;
    logic              vld1_q;
    logic [SEL_W-1:0]  sel1_q, sel1_d;

    logic              s_ready_d, busy_d, frame_done_d, data_out_valid_d, rd_en;
    logic [DATA_W-1:0] data_out_d;
    logic [SEL_W-1:0]  block_sel_d;

    logic accept, last_addr, last_pass;
    assign accept    = s_valid & s_ready;
    assign last_addr = (rd_cnt_q == LAST_ADDR);
    assign last_pass = (pass_q == LAST_PASS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FILL;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            pass_q    <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            pass_q    <= pass_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        pass_d    = pass_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    if (wr_cnt_q == LAST_ADDR) begin
                        wr_cnt_d = '0;
                        state_d  = STREAM;
                    end else begin
                        wr_cnt_d = wr_cnt_q + CW'(1);
                    end
                end
            end
            STREAM: begin
                if (last_addr) begin
                    rd_cnt_d = '0;
                    if (last_pass) begin
                        state_d   = GAP;
                        gap_cnt_d = GW'(GAP_CYCLES + 1);
                    end else if (GAP_CYCLES == 0) begin
                        pass_d = pass_q + SEL_W'(1);
                    end else begin
                        state_d   = GAP;
                        gap_cnt_d = GW'(GAP_CYCLES - 1);
                    end
                end else begin
                    rd_cnt_d = rd_cnt_q + CW'(1);
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    if (last_pass) begin
                        state_d = DONE;
                    end else begin
                        pass_d  = pass_q + SEL_W'(1);
                        state_d = STREAM;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                end
            end
            DONE: begin
                pass_d  = '0;
                state_d = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        s_ready_d        = (state_d == FILL);
        busy_d           = (state_d != FILL);
        frame_done_d     = (state_d == DONE);
        rd_en            = (state_q == STREAM);
        data_out_valid_d = vld1_q;
        data_out_d       = vld1_q ? ram_q : data_out;
        // block_sel travels with the read pipeline so it lines up with its pass's words.
        sel1_d           = (state_q == DONE) ? '0 : pass_q;
        block_sel_d      = (state_q == DONE) ? '0 : sel1_q;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_cnt_q] <= s_data;
        end
        if (rd_en) begin
            ram_q <= mem[rd_cnt_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld1_q         <= 1'b0;
            sel1_q         <= '0;
            s_ready        <= 1'b1;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            block_sel      <= '0;
        end else begin
            vld1_q         <= rd_en;
            sel1_q         <= sel1_d;
            s_ready        <= s_ready_d;
            busy           <= busy_d;
            frame_done     <= frame_done_d;
            data_out       <= data_out_d;
            data_out_valid <= data_out_valid_d;
            block_sel      <= block_sel_d;
        end
    end

endmodule

// File: tb/tb_qkv_frame_feeder.sv
// Self-checking bench for qkv_frame_feeder: default instance plus a short-frame, zero-gap instance.
module tb_qkv_frame_feeder;

    localparam int L  = 30;
    localparam int N  = 3;
    localparam int G  = 4;
    localparam int L2 = 2;
    localparam int N2 = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] data_out;
    logic        data_out_valid;
    logic [1:0]  block_sel;
    logic        frame_done;
    logic        busy;

    logic [15:0] s_data_s;
    logic        s_valid_s;
    logic        s_ready_s;
    logic [15:0] data_out_s;
    logic        data_out_valid_s;
    logic [1:0]  block_sel_s;
    logic        frame_done_s;
    logic        busy_s;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_words [L];

    qkv_frame_feeder #(.DATA_W(16), .FRAME_LEN(L), .NUM_PASS(N), .SEL_W(2), .GAP_CYCLES(G)) u_dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .data_out(data_out), .data_out_valid(data_out_valid), .block_sel(block_sel),
        .frame_done(frame_done), .busy(busy)
    );

    qkv_frame_feeder #(.DATA_W(16), .FRAME_LEN(L2), .NUM_PASS(N2), .SEL_W(2), .GAP_CYCLES(0)) u_small (
        .clk(clk), .rst_n(rst_n), .s_data(s_data_s), .s_valid(s_valid_s), .s_ready(s_ready_s),
        .data_out(data_out_s), .data_out_valid(data_out_valid_s), .block_sel(block_sel_s),
        .frame_done(frame_done_s), .busy(busy_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic load_words(input bit rnd, input logic [15:0] base);
        for (int i = 0; i < L; i++) begin
            exp_words[i] = rnd ? 16'($urandom) : base + 16'(i);
        end
    endtask

    // Feeds exp_words; returns just after the posedge of the final accept.
    task automatic feed_frame(input bit throttle);
        int  i;
        int  guard;
        bit  acc;
        i = 0;
        guard = 0;
        while (i < L) begin
            @(negedge clk);
            if (throttle && ($urandom_range(0, 1) == 0)) begin
                s_valid = 1'b0;
                s_data  = 16'($urandom);
            end else begin
                s_valid = 1'b1;
                s_data  = exp_words[i];
            end
            acc = s_valid && s_ready;
            @(posedge clk);
            if (acc) i++;
            guard++;
            if (guard > 2000) begin
                total++; bad++;
                $display("FAIL feed_timeout accepted=%0d required=%0d", i, L);
                return;
            end
        end
    endtask

    // t counts posedges after the final accept; expectations come from pass/gap arithmetic.
    task automatic check_replay(input int stop_at, input bit hold_dead);
        int period, done_t, off, p, k;
        bit exp_v;
        period = L + G;
        done_t = 2 + N * period;
        for (int t = 0; t <= done_t + 1; t++) begin
            @(negedge clk);
            off   = t - 2;
            p     = (off >= 0) ? off / period : 0;
            k     = (off >= 0) ? off % period : 0;
            exp_v = (off >= 0) && (p < N) && (k < L);
            total++;
            if (data_out_valid !== exp_v) begin
                bad++;
                $display("FAIL valid t=%0d got=%b exp=%b", t, data_out_valid, exp_v);
            end
            if (exp_v) begin
                total++;
                if (data_out !== exp_words[k]) begin
                    bad++;
                    $display("FAIL data t=%0d got=%h exp=%h", t, data_out, exp_words[k]);
                end
                total++;
                if (block_sel !== 2'(p)) begin
                    bad++;
                    $display("FAIL block_sel t=%0d got=%0d exp=%0d", t, block_sel, p);
                end
            end else if (off >= L) begin
                total++;
                if (data_out !== exp_words[L-1]) begin
                    bad++;
                    $display("FAIL data_hold t=%0d got=%h exp=%h", t, data_out, exp_words[L-1]);
                end
            end
            total++;
            if (frame_done !== (t == done_t)) begin
                bad++;
                $display("FAIL frame_done t=%0d got=%b exp=%b", t, frame_done, (t == done_t));
            end
            total++;
            if (s_ready !== (t > done_t) || busy !== (t <= done_t)) begin
                bad++;
                $display("FAIL ready_busy t=%0d got=%b%b exp=%b%b", t, s_ready, busy, (t > done_t), (t <= done_t));
            end
            if (hold_dead) begin
                total++;
                if (data_out === 16'hDEAD) begin
                    bad++;
                    $display("FAIL dead_leak t=%0d got=%h", t, data_out);
                end
            end
            if (t == stop_at) return;
            s_valid = hold_dead && (t <= done_t);
            s_data  = hold_dead ? 16'hDEAD : 16'($urandom);
        end
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        s_valid = 1'b1;
        s_data  = 16'h1234;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            s_data = 16'($urandom);
            total++;
            if (s_ready !== 1'b1 || data_out_valid !== 1'b0 || block_sel !== 2'd0 ||
                frame_done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL reset c=%0d got rdy=%b vld=%b sel=%0d fd=%b busy=%b exp 1 0 0 0 0",
                         c, s_ready, data_out_valid, block_sel, frame_done, busy);
            end
            total++;
            if (s_ready_s !== 1'b1 || data_out_valid_s !== 1'b0 || busy_s !== 1'b0) begin
                bad++;
                $display("FAIL reset_small c=%0d got rdy=%b vld=%b busy=%b", c, s_ready_s, data_out_valid_s, busy_s);
            end
        end
        s_valid = 1'b0;
        rst_n   = 1'b1;
    endtask

    task automatic test_nominal();
        load_words(1'b0, 16'h0001);
        feed_frame(1'b0);
        check_replay(-1, 1'b0);
    endtask

    task automatic test_throttle();
        load_words(1'b0, 16'h0001);
        feed_frame(1'b1);
        check_replay(-1, 1'b0);
        load_words(1'b1, 16'h0000);
        feed_frame(1'b1);
        check_replay(-1, 1'b0);
    endtask

    task automatic test_busy_ignore();
        load_words(1'b1, 16'h0000);
        feed_frame(1'b0);
        check_replay(-1, 1'b1);
    endtask

    task automatic test_mid_reset();
        load_words(1'b1, 16'h0000);
        feed_frame(1'b0);
        check_replay(2 + (L + G) + 10, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (data_out_valid !== 1'b0 || block_sel !== 2'd0 || s_ready !== 1'b1 ||
            busy !== 1'b0 || frame_done !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset got vld=%b sel=%0d rdy=%b busy=%b fd=%b exp 0 0 1 0 0",
                     data_out_valid, block_sel, s_ready, busy, frame_done);
        end
        rst_n = 1'b1;
        load_words(1'b0, 16'h0100);
        feed_frame(1'b0);
        check_replay(-1, 1'b0);
    endtask

    task automatic test_small_params();
        logic [15:0] w [L2];
        int  i, guard, off, done_t;
        bit  acc, exp_v;
        for (int j = 0; j < L2; j++) w[j] = 16'($urandom);
        i = 0;
        guard = 0;
        while (i < L2 && guard < 100) begin
            @(negedge clk);
            s_valid_s = 1'b1;
            s_data_s  = w[i];
            acc = s_valid_s && s_ready_s;
            @(posedge clk);
            if (acc) i++;
            guard++;
        end
        total++;
        if (i != L2) begin
            bad++;
            $display("FAIL small_feed accepted=%0d required=%0d", i, L2);
        end
        done_t = 2 + N2 * L2;
        for (int t = 0; t <= done_t + 1; t++) begin
            @(negedge clk);
            s_valid_s = 1'b0;
            off   = t - 2;
            exp_v = (off >= 0) && (off < N2 * L2);
            total++;
            if (data_out_valid_s !== exp_v) begin
                bad++;
                $display("FAIL small_valid t=%0d got=%b exp=%b", t, data_out_valid_s, exp_v);
            end
            if (exp_v) begin
                total++;
                if (data_out_s !== w[off % L2] || block_sel_s !== 2'(off / L2)) begin
                    bad++;
                    $display("FAIL small_word t=%0d got=%h/%0d exp=%h/%0d", t, data_out_s, block_sel_s,
                             w[off % L2], off / L2);
                end
            end
            total++;
            if (frame_done_s !== (t == done_t) || s_ready_s !== (t > done_t)) begin
                bad++;
                $display("FAIL small_done t=%0d got fd=%b rdy=%b exp fd=%b rdy=%b", t, frame_done_s,
                         s_ready_s, (t == done_t), (t > done_t));
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        s_valid_s = 1'b0;
        s_data_s  = '0;
        test_reset();
        test_nominal();
        test_throttle();
        test_busy_ignore();
        test_mid_reset();
        test_small_params();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
